// File: rtl/periph_regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : periph_regbank_pkg
//  Description : Word map, control-bit positions, timer state encoding and
//                small address/byte-lane helpers for the peripheral bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package periph_regbank_pkg;

   // Fixed word offsets (bus addr[7:2])
   localparam logic [5:0] A_CNAME       = 6'd0;
   localparam logic [5:0] A_CVERSION    = 6'd1;
   localparam logic [5:0] A_SCRATCH     = 6'd2;
   localparam logic [5:0] A_GPIO_OUT    = 6'd3;
   localparam logic [5:0] A_GPIO_OE     = 6'd4;
   localparam logic [5:0] A_GPIO_PIN    = 6'd5;
   localparam logic [5:0] A_GPIO_IMASK  = 6'd6;
   localparam logic [5:0] A_GPIO_EDGE   = 6'd7;
   localparam logic [5:0] A_GPIO_ISTAT  = 6'd8;
   localparam logic [5:0] A_TIMER_IMASK = 6'd9;

   // Timer channel windows: base + stride*n + register offset
   localparam int TIMER_BASE   = 16;
   localparam int TIMER_STRIDE = 4;
   localparam int T_CTRL       = 0;
   localparam int T_TERM       = 1;
   localparam int T_CURR       = 2;
   localparam int T_STAT       = 3;

   // CTRLn / STATn bit positions
   localparam int CTRL_START    = 0;
   localparam int CTRL_HALT     = 1;
   localparam int CTRL_PERIODIC = 2;
   localparam int CTRL_RUNNING  = 3;
   localparam int STAT_DONE     = 0;

   typedef enum logic [0:0] {
      T_IDLE = 1'b0,
      T_RUN  = 1'b1
   } timer_state_t;

   // Word address of register 'off' inside timer channel 'n'
   function automatic logic [5:0] timer_addr(input int n, input int off);
      return 6'(TIMER_BASE + TIMER_STRIDE * n + off);
   endfunction

   // Expand the four byte enables into a 32-bit bit mask
   function automatic logic [31:0] byte_mask(input logic [3:0] wben);
      return {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/periph_regbank_if.sv
`default_nettype none
// ============================================================================
//  Module      : periph_regbank_if
//  Description : Word-addressed slave bus of the peripheral register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
interface periph_regbank_if;
   logic        req;
   logic        r_wn;
   logic [7:2]  addr;
   logic [3:0]  wben;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (output req, r_wn, addr, wben, wdata, input  rdata, rvalid);
   modport slave  (input  req, r_wn, addr, wben, wdata, output rdata, rvalid);
endinterface
`default_nettype wire

// File: rtl/periph_regbank_timer_chan.sv
`default_nettype none
// ============================================================================
//  Module      : timer_chan
//  Description : One count-up timer channel with one-shot / periodic modes,
//                start/halt strobes and a sticky DONE flag (set beats clear).
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_chan
   import periph_regbank_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        reset_n,
   input  wire logic        start,
   input  wire logic        halt,
   input  wire logic        periodic,
   input  wire logic [31:0] term,
   input  wire logic        done_clr,
   output      logic [31:0] curr,
   output      logic        running,
   output      logic        done
);

   timer_state_t r_state, w_state_nxt;
   logic [31:0]  r_curr,  w_curr_nxt;
   logic         r_done,  w_done_nxt;
   logic         w_done_set;

   // State, counter and DONE flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= T_IDLE;
         r_curr  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_curr  <= w_curr_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next state: halt beats start; the compare uses the live TERM value so a
   // TERM rewrite during a run applies at the next compare
   always_comb begin
      w_state_nxt = r_state;
      w_curr_nxt  = r_curr;
      w_done_set  = 1'b0;
      if (halt) begin
         w_state_nxt = T_IDLE;
      end else if (start) begin
         w_state_nxt = T_RUN;
         w_curr_nxt  = '0;
      end else if (r_state == T_RUN) begin
         if (r_curr == term) begin
            w_done_set = 1'b1;
            if (periodic) w_curr_nxt  = '0;
            else          w_state_nxt = T_IDLE;
         end else begin
            w_curr_nxt = r_curr + 32'd1;
         end
      end
      w_done_nxt = (r_done & ~done_clr) | w_done_set;
   end

   assign curr    = r_curr;
   assign running = (r_state == T_RUN);
   assign done    = r_done;

endmodule
`default_nettype wire

// File: rtl/periph_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : periph_regbank
//  Description : Peripheral register bank: chip ID, scratch, GPIO with
//                synchronised inputs and edge interrupts, NUM_TIMERS timers
//                and a combined registered interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_regbank
   import periph_regbank_pkg::*;
#(
   parameter int          GPIO_W       = 16,
   parameter int          NUM_TIMERS   = 2,
   parameter logic [31:0] CHIP_NAME    = 32'h48524a44,
   parameter logic [31:0] CHIP_VERSION = 32'h00020000
)
(
   input  wire logic              clk,
   input  wire logic              reset_n,
   periph_regbank_if.slave        bus,
   input  wire logic [GPIO_W-1:0] gpio_pin_in,
   output      logic [GPIO_W-1:0] gpio_out,
   output      logic [GPIO_W-1:0] gpio_oe,
   output      logic              irq
);

   logic                  w_wr, w_rd;
   logic [5:0]            w_addr;
   logic [31:0]           w_bmask, w_wmasked, w_rdata_nxt;
   logic [31:0]           r_rdata, r_scratch;
   logic                  r_rvalid, r_irq;
   logic [GPIO_W-1:0]     r_gpio_out, r_gpio_oe, r_gpio_imask, r_gpio_edge, r_gpio_istat;
   logic [GPIO_W-1:0]     r_sync1, r_sync2, r_pin_prev;
   logic [GPIO_W-1:0]     w_edge_hit, w_istat_clr;
   logic [NUM_TIMERS-1:0] r_timer_imask;
   logic [NUM_TIMERS-1:0] w_done, w_running, w_periodic;
   logic [31:0]           w_term [NUM_TIMERS];
   logic [31:0]           w_curr [NUM_TIMERS];

   assign w_addr    = bus.addr;
   assign w_wr      = bus.req & ~bus.r_wn;
   assign w_rd      = bus.req &  bus.r_wn;
   assign w_bmask   = byte_mask(bus.wben);
   assign w_wmasked = bus.wdata & w_bmask;

   // Two-flop pin synchroniser plus the previous-value flop for edge detect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_pin_prev <= '0;
      end else begin
         r_sync1    <= gpio_pin_in;
         r_sync2    <= r_sync1;
         r_pin_prev <= r_sync2;
      end
   end

   assign w_edge_hit  = (r_sync2 & ~r_pin_prev & ~r_gpio_edge) |
                        (~r_sync2 & r_pin_prev &  r_gpio_edge);
   assign w_istat_clr = (w_wr && w_addr == A_GPIO_ISTAT) ? w_wmasked[GPIO_W-1:0] : '0;

   // Edge status: hardware set wins over a same-cycle write-1-to-clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_gpio_istat <= '0;
      else          r_gpio_istat <= (r_gpio_istat & ~w_istat_clr) | w_edge_hit;
   end

   // Plain read/write configuration registers with byte-lane merge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scratch     <= '0;
         r_gpio_out    <= '0;
         r_gpio_oe     <= '0;
         r_gpio_imask  <= '0;
         r_gpio_edge   <= '0;
         r_timer_imask <= '0;
      end else if (w_wr) begin
         case (w_addr)
            A_SCRATCH:     r_scratch     <= (r_scratch & ~w_bmask) | w_wmasked;
            A_GPIO_OUT:    r_gpio_out    <= (r_gpio_out   & ~w_bmask[GPIO_W-1:0]) | w_wmasked[GPIO_W-1:0];
            A_GPIO_OE:     r_gpio_oe     <= (r_gpio_oe    & ~w_bmask[GPIO_W-1:0]) | w_wmasked[GPIO_W-1:0];
            A_GPIO_IMASK:  r_gpio_imask  <= (r_gpio_imask & ~w_bmask[GPIO_W-1:0]) | w_wmasked[GPIO_W-1:0];
            A_GPIO_EDGE:   r_gpio_edge   <= (r_gpio_edge  & ~w_bmask[GPIO_W-1:0]) | w_wmasked[GPIO_W-1:0];
            A_TIMER_IMASK: r_timer_imask <= (r_timer_imask & ~w_bmask[NUM_TIMERS-1:0]) |
                                            w_wmasked[NUM_TIMERS-1:0];
            default: ;
         endcase
      end
   end

   for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_timer
      logic        w_ctrl_wr, w_term_wr, w_stat_wr;
      logic        r_periodic;
      logic [31:0] r_term;

      assign w_ctrl_wr = w_wr && (w_addr == timer_addr(n, T_CTRL)) && bus.wben[0];
      assign w_term_wr = w_wr && (w_addr == timer_addr(n, T_TERM));
      assign w_stat_wr = w_wr && (w_addr == timer_addr(n, T_STAT)) && bus.wben[0];

      // Per-channel PERIODIC mode bit and terminal count
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_periodic <= 1'b0;
            r_term     <= '0;
         end else begin
            if (w_ctrl_wr) r_periodic <= bus.wdata[CTRL_PERIODIC];
            if (w_term_wr) r_term     <= (r_term & ~w_bmask) | w_wmasked;
         end
      end

      timer_chan u_timer_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .start    (w_ctrl_wr & bus.wdata[CTRL_START]),
         .halt     (w_ctrl_wr & bus.wdata[CTRL_HALT]),
         .periodic (r_periodic),
         .term     (r_term),
         .done_clr (w_stat_wr & bus.wdata[STAT_DONE]),
         .curr     (w_curr[n]),
         .running  (w_running[n]),
         .done     (w_done[n])
      );

      assign w_periodic[n] = r_periodic;
      assign w_term[n]     = r_term;
   end

   // Read mux; unmapped words and bits above a register's width read 0
   always_comb begin
      w_rdata_nxt = '0;
      case (w_addr)
         A_CNAME:       w_rdata_nxt = CHIP_NAME;
         A_CVERSION:    w_rdata_nxt = CHIP_VERSION;
         A_SCRATCH:     w_rdata_nxt = r_scratch;
         A_GPIO_OUT:    w_rdata_nxt[GPIO_W-1:0] = r_gpio_out;
         A_GPIO_OE:     w_rdata_nxt[GPIO_W-1:0] = r_gpio_oe;
         A_GPIO_PIN:    w_rdata_nxt[GPIO_W-1:0] = r_sync2;
         A_GPIO_IMASK:  w_rdata_nxt[GPIO_W-1:0] = r_gpio_imask;
         A_GPIO_EDGE:   w_rdata_nxt[GPIO_W-1:0] = r_gpio_edge;
         A_GPIO_ISTAT:  w_rdata_nxt[GPIO_W-1:0] = r_gpio_istat;
         A_TIMER_IMASK: w_rdata_nxt[NUM_TIMERS-1:0] = r_timer_imask;
         default: ;
      endcase
      for (int n = 0; n < NUM_TIMERS; n++) begin
         if (w_addr == timer_addr(n, T_CTRL)) begin
            w_rdata_nxt[CTRL_PERIODIC] = w_periodic[n];
            w_rdata_nxt[CTRL_RUNNING]  = w_running[n];
         end
         if (w_addr == timer_addr(n, T_TERM)) w_rdata_nxt = w_term[n];
         if (w_addr == timer_addr(n, T_CURR)) w_rdata_nxt = w_curr[n];
         if (w_addr == timer_addr(n, T_STAT)) w_rdata_nxt[STAT_DONE] = w_done[n];
      end
   end

   // Registered read response and combined interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_rvalid <= w_rd;
         if (w_rd) r_rdata <= w_rdata_nxt;
         r_irq <= (|(r_gpio_istat & r_gpio_imask)) | (|(w_done & r_timer_imask));
      end
   end

   assign bus.rdata  = r_rdata;
   assign bus.rvalid = r_rvalid;
   assign gpio_out   = r_gpio_out;
   assign gpio_oe    = r_gpio_oe;
   assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_periph_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_periph_regbank
//  Description : Directed self-checking bench for periph_regbank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_regbank;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] gpio_pin_in;
   logic [15:0] gpio_out;
   logic [15:0] gpio_oe;
   logic        irq;
   int          checks   = 0;
   int          failures = 0;

   periph_regbank_if bus_if ();

   periph_regbank #(.GPIO_W(16), .NUM_TIMERS(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus_if),
      .gpio_pin_in (gpio_pin_in),
      .gpio_out    (gpio_out),
      .gpio_oe     (gpio_oe),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   // Every bus task starts and ends on a falling edge: one access per cycle
   task automatic bus_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
      bus_if.req   = 1'b1;
      bus_if.r_wn  = 1'b0;
      bus_if.addr  = a;
      bus_if.wben  = be;
      bus_if.wdata = d;
      @(negedge clk);
      bus_if.req   = 1'b0;
      bus_if.wben  = 4'h0;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output logic v);
      bus_if.req  = 1'b1;
      bus_if.r_wn = 1'b1;
      bus_if.addr = a;
      @(negedge clk);
      bus_if.req  = 1'b0;
      d = bus_if.rdata;
      v = bus_if.rvalid;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      reset_n = 1'b0;
      idle(3);
      checks++;
      if ({gpio_out, gpio_oe, irq, bus_if.rvalid, bus_if.rdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: out=%h oe=%h irq=%b rvalid=%b rdata=%h, want all 0",
                  gpio_out, gpio_oe, irq, bus_if.rvalid, bus_if.rdata);
      end
      reset_n = 1'b1;
      idle(1);
      bus_read(6'd0, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h48524a44) begin
         failures++; $display("FAIL cname: rdata=%h rvalid=%b, want 48524a44/1", d, v);
      end
      bus_read(6'd1, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h00020000) begin
         failures++; $display("FAIL cversion: rdata=%h rvalid=%b, want 00020000/1", d, v);
      end
      bus_read(6'd2, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
         failures++; $display("FAIL scratch_reset: rdata=%h rvalid=%b, want 0/1", d, v);
      end
      idle(1);
      checks++;
      if (bus_if.rvalid !== 1'b0) begin
         failures++; $display("FAIL rvalid_pulse: rvalid=%b, want 0", bus_if.rvalid);
      end
   endtask

   task automatic test_scratch_unmapped();
      logic [31:0] d; logic v;
      bus_write(6'd2, 4'b0101, 32'hAABBCCDD);
      bus_read(6'd2, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h00BB00DD) begin
         failures++; $display("FAIL scratch_bytes: rdata=%h rvalid=%b, want 00bb00dd/1", d, v);
      end
      bus_read(6'd10, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
         failures++; $display("FAIL unmapped_10: rdata=%h rvalid=%b, want 0/1", d, v);
      end
      bus_write(6'd11, 4'hF, 32'hFFFFFFFF);
      bus_read(6'd11, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
         failures++; $display("FAIL unmapped_11: rdata=%h rvalid=%b, want 0/1", d, v);
      end
      bus_read(6'd24, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
         failures++; $display("FAIL unmapped_timer2: rdata=%h rvalid=%b, want 0/1", d, v);
      end
   endtask

   task automatic test_gpio();
      logic [31:0] d; logic v; int seen;
      bus_write(6'd3, 4'hF, 32'hFFFF1234);
      bus_read(6'd3, d, v);
      checks++;
      if (d !== 32'h00001234 || gpio_out !== 16'h1234) begin
         failures++; $display("FAIL gpio_out: rdata=%h port=%h, want 00001234/1234", d, gpio_out);
      end
      bus_write(6'd4, 4'b0001, 32'h0000ABCD);
      bus_read(6'd4, d, v);
      checks++;
      if (d !== 32'h000000CD || gpio_oe !== 16'h00CD) begin
         failures++; $display("FAIL gpio_oe: rdata=%h port=%h, want 000000cd/00cd", d, gpio_oe);
      end
      gpio_pin_in = 16'h1234;
      idle(3);
      bus_read(6'd5, d, v);
      checks++;
      if (d !== 32'h00001234) begin
         failures++; $display("FAIL gpio_pin: rdata=%h, want 00001234", d);
      end
      bus_read(6'd8, d, v);
      checks++;
      if (d !== 32'h00001234 || irq !== 1'b0) begin
         failures++; $display("FAIL istat_rise_masked: rdata=%h irq=%b, want 00001234/0", d, irq);
      end
      gpio_pin_in = 16'h0000;
      idle(4);
      bus_write(6'd8, 4'b0011, 32'h0000FFFF);
      bus_read(6'd8, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL istat_w1c_all: rdata=%h, want 0", d);
      end
      bus_write(6'd6, 4'hF, 32'h1);
      bus_write(6'd7, 4'hF, 32'h0);
      gpio_pin_in[0] = 1'b1;
      seen = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (irq === 1'b1) begin seen = i; break; end
      end
      checks++;
      if (seen == 0 || seen > 4) begin
         failures++; $display("FAIL gpio_irq_latency: cycles=%0d, want 1..4", seen);
      end
      bus_read(6'd8, d, v);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL istat_bit0: rdata=%h, want 1", d);
      end
      bus_write(6'd8, 4'hF, 32'h1);
      bus_read(6'd8, d, v);
      checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         failures++; $display("FAIL istat_w1c: rdata=%h irq=%b, want 0/0", d, irq);
      end
      gpio_pin_in[0] = 1'b0;
      idle(5);
      bus_read(6'd8, d, v);
      checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         failures++; $display("FAIL falling_ignored: rdata=%h irq=%b, want 0/0", d, irq);
      end
   endtask

   task automatic test_timer_oneshot();
      logic [31:0] d; logic v;
      bus_write(6'd17, 4'hF, 32'd5);
      bus_write(6'd16, 4'hF, 32'h1);
      for (int k = 0; k <= 5; k++) begin
         bus_read(6'd18, d, v);
         checks++;
         if (d !== 32'(k)) begin
            failures++; $display("FAIL oneshot_curr[%0d]: rdata=%0d, want %0d", k, d, k);
         end
      end
      bus_read(6'd18, d, v);
      checks++;
      if (d !== 32'd5) begin
         failures++; $display("FAIL oneshot_hold: rdata=%0d, want 5", d);
      end
      bus_read(6'd19, d, v);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL oneshot_done: rdata=%h, want 1", d);
      end
      bus_read(6'd16, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL oneshot_ctrl: rdata=%h, want 0", d);
      end
   endtask

   task automatic test_timer_periodic();
      logic [31:0] d; logic v;
      bus_write(6'd19, 4'hF, 32'h1);
      bus_write(6'd16, 4'hF, 32'h5);
      for (int k = 0; k < 12; k++) begin
         bus_read(6'd18, d, v);
         checks++;
         if (d !== 32'(k % 6)) begin
            failures++; $display("FAIL periodic_curr[%0d]: rdata=%0d, want %0d", k, d, k % 6);
         end
      end
      bus_write(6'd19, 4'hF, 32'h1);
      for (int k = 0; k < 6; k++) begin
         bus_read(6'd19, d, v);
         checks++;
         if (d !== ((k == 5) ? 32'h1 : 32'h0)) begin
            failures++; $display("FAIL periodic_done[%0d]: rdata=%h, want %0d", k, d, (k == 5));
         end
      end
   endtask

   task automatic test_halt_restart();
      logic [31:0] d; logic v;
      bus_write(6'd16, 4'hF, 32'h3);
      for (int k = 0; k < 2; k++) begin
         bus_read(6'd18, d, v);
         checks++;
         if (d !== 32'd1) begin
            failures++; $display("FAIL halt_frozen[%0d]: rdata=%0d, want 1", k, d);
         end
      end
      bus_read(6'd16, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL halt_ctrl: rdata=%h, want 0", d);
      end
      bus_write(6'd16, 4'hF, 32'h1);
      for (int k = 0; k < 2; k++) begin
         bus_read(6'd18, d, v);
         checks++;
         if (d !== 32'(k)) begin
            failures++; $display("FAIL restart_curr[%0d]: rdata=%0d, want %0d", k, d, k);
         end
      end
      bus_read(6'd16, d, v);
      checks++;
      if (d !== 32'h8) begin
         failures++; $display("FAIL restart_running: rdata=%h, want 8", d);
      end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d; logic v;
      bus_write(6'd3, 4'hF, 32'h00F0);
      bus_read(6'd18, d, v);
      checks++;
      if (d !== 32'd4 || bus_if.rvalid !== 1'b1) begin
         failures++; $display("FAIL midcount_curr: rdata=%0d rvalid=%b, want 4/1", d, bus_if.rvalid);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (gpio_out !== 16'h0 || bus_if.rvalid !== 1'b0 || bus_if.rdata !== 32'h0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: out=%h rvalid=%b rdata=%h irq=%b, want 0",
                  gpio_out, bus_if.rvalid, bus_if.rdata, irq);
      end
      idle(2);
      reset_n = 1'b1;
      idle(1);
      bus_read(6'd18, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL reset_curr: rdata=%0d, want 0", d);
      end
      bus_read(6'd16, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL reset_ctrl: rdata=%h, want 0", d);
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] d; logic v;
      gpio_pin_in[0] = 1'b1;
      idle(2);
      bus_write(6'd8, 4'hF, 32'h1);
      bus_read(6'd8, d, v);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL istat_set_wins: rdata=%h, want 1", d);
      end
      bus_write(6'd17, 4'hF, 32'd2);
      bus_write(6'd16, 4'hF, 32'h1);
      idle(2);
      bus_write(6'd19, 4'hF, 32'h1);
      bus_read(6'd19, d, v);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL done_set_wins: rdata=%h, want 1", d);
      end
      bus_write(6'd19, 4'hF, 32'h1);
      bus_read(6'd19, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL done_w1c: rdata=%h, want 0", d);
      end
   endtask

   task automatic test_term_zero();
      logic [31:0] d; logic v;
      bus_write(6'd9, 4'hF, 32'h2);
      bus_write(6'd21, 4'hF, 32'h0);
      checks++;
      if (irq !== 1'b0) begin
         failures++; $display("FAIL irq_before_done1: irq=%b, want 0", irq);
      end
      bus_write(6'd20, 4'hF, 32'h1);
      bus_read(6'd23, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL term0_stat_early: rdata=%h, want 0", d);
      end
      bus_read(6'd23, d, v);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL term0_done: rdata=%h, want 1", d);
      end
      bus_read(6'd22, d, v);
      checks++;
      if (d !== 32'h0 || irq !== 1'b1) begin
         failures++; $display("FAIL term0_curr_irq: rdata=%h irq=%b, want 0/1", d, irq);
      end
      bus_read(6'd20, d, v);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL term0_idle: rdata=%h, want 0", d);
      end
   endtask

   initial begin
      bus_if.req   = 1'b0;
      bus_if.r_wn  = 1'b1;
      bus_if.addr  = 6'd0;
      bus_if.wben  = 4'h0;
      bus_if.wdata = 32'h0;
      gpio_pin_in  = 16'h0;
      reset_n      = 1'b0;
      @(negedge clk);
      test_reset();
      test_scratch_unmapped();
      test_gpio();
      test_timer_oneshot();
      test_timer_periodic();
      test_halt_restart();
      test_reset_midcount();
      test_same_cycle();
      test_term_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
